// File: rtl/freq_meter.sv
`default_nettype none
//======================================================================
// Module      : freq_meter
// Description : Gated frequency counter. Counts rising edges of an
//               asynchronous input over a fixed window of GATE_CYCLES
//               clocks, publishes the count with a one-cycle strobe and
//               immediately starts the next window.
// Revision    : 1.0  initial release
//======================================================================
module freq_meter #(
   parameter int GATE_CYCLES = 1000,
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             sig_i,
   output logic [CNT_W-1:0] freq_o,
   output logic             valid_o,
   output logic             ovf_o,
   output logic             busy_o
);

   localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int ARM_W  = $clog2(SYNC_STAGES + 1);

   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(SYNC_STAGES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_GATE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist;
   logic                   rise;

   logic [ARM_W-1:0]  arm_cnt;
   logic [GATE_W-1:0] gate_cnt;
   logic [CNT_W-1:0]  edge_cnt;
   logic              ovf_flag;

   logic              arm_done;
   logic              gate_last;
   logic [CNT_W-1:0]  edge_sat;
   logic              ovf_now;

   // Synchronizer chain plus one history flop for rising-edge detection
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         sync_q <= '0;
         hist   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
         hist   <= sync_q[SYNC_STAGES-1];
      end
   end

   // Edge pulse, saturating increment and window/arm terminal conditions
   always_comb begin
      rise      = sync_q[SYNC_STAGES-1] & ~hist;
      ovf_now   = rise && (edge_cnt == CNT_MAX);
      edge_sat  = edge_cnt;
      if (rise && (edge_cnt != CNT_MAX)) begin
         edge_sat = edge_cnt + CNT_W'(1);
      end
      arm_done  = (arm_cnt == ARM_LAST);
      gate_last = (gate_cnt == GATE_LAST);
      busy_o    = (state != S_IDLE);
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: disable aborts from any state, windows run back-to-back
   always_comb begin
      state_nxt = state;
      if (!en_i) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  state_nxt = S_ARM;
            S_ARM:   if (arm_done) state_nxt = S_GATE;
            S_GATE:  state_nxt = S_GATE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Counters and published result; partial windows are dropped on abort
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         arm_cnt  <= '0;
         gate_cnt <= '0;
         edge_cnt <= '0;
         ovf_flag <= 1'b0;
         freq_o   <= '0;
         ovf_o    <= 1'b0;
         valid_o  <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         if (en_i) begin
            case (state)
               S_IDLE: begin
                  arm_cnt  <= '0;
                  gate_cnt <= '0;
                  edge_cnt <= '0;
                  ovf_flag <= 1'b0;
               end
               S_ARM: begin
                  arm_cnt <= arm_cnt + ARM_W'(1);
               end
               S_GATE: begin
                  if (gate_last) begin
                     freq_o   <= edge_sat;
                     ovf_o    <= ovf_flag | ovf_now;
                     valid_o  <= 1'b1;
                     gate_cnt <= '0;
                     edge_cnt <= '0;
                     ovf_flag <= 1'b0;
                  end else begin
                     gate_cnt <= gate_cnt + GATE_W'(1);
                     edge_cnt <= edge_sat;
                     ovf_flag <= ovf_flag | ovf_now;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
//======================================================================
// Module      : tb_freq_meter
// Description : Self-checking bench for freq_meter. Two instances share
//               stimulus (16-bit and 4-bit counters); a window-level
//               reference model counts sampled 0->1 transitions.
// Revision    : 1.0  initial release
//======================================================================
module tb_freq_meter;

   localparam int GATE = 100;
   localparam int SYNC = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic en    = 1'b0;
   logic sig   = 1'b0;

   logic [15:0] freq_a;
   logic        valid_a, ovf_a, busy_a;
   logic [3:0]  freq_b;
   logic        valid_b, ovf_b, busy_b;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   freq_meter #(.GATE_CYCLES(GATE), .CNT_W(16), .SYNC_STAGES(SYNC)) dut_a (
      .clk_i(clk), .rst_i(rst_n), .en_i(en), .sig_i(sig),
      .freq_o(freq_a), .valid_o(valid_a), .ovf_o(ovf_a), .busy_o(busy_a)
   );

   freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4), .SYNC_STAGES(SYNC)) dut_b (
      .clk_i(clk), .rst_i(rst_n), .en_i(en), .sig_i(sig),
      .freq_o(freq_b), .valid_o(valid_b), .ovf_o(ovf_b), .busy_o(busy_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Signal source: 0 = periodic, 1 = random run lengths, 2 = held high
   int sig_mode   = 0;
   int sig_period = 10;
   int sig_phase  = 0;
   int run_left   = 0;
   always @(negedge clk) begin
      sig_phase++;
      case (sig_mode)
         0: sig = ((sig_phase % sig_period) < (sig_period / 2));
         1: begin
            if (run_left == 0) begin
               sig      = ~sig;
               run_left = $urandom_range(2, 8);
            end else begin
               run_left--;
            end
         end
         default: sig = 1'b1;
      endcase
   end

   // Reference model: windows defined by edge indices, counting transitions of sampled sig
   bit          samp [0:65535];
   int          k     = 0;
   int          start = 0;
   bit          meas  = 0;
   logic        exp_valid = 1'b0;
   logic        exp_busy  = 1'b0;
   logic [15:0] exp_fa    = '0;
   logic        exp_oa    = 1'b0;
   logic [3:0]  exp_fb    = '0;
   logic        exp_ob    = 1'b0;

   always @(posedge clk) begin
      int n;
      k++;
      samp[k]   = rst_n ? sig : 1'b0;
      exp_valid = 1'b0;
      if (!rst_n) begin
         meas   = 0;
         exp_fa = '0;
         exp_oa = 1'b0;
         exp_fb = '0;
         exp_ob = 1'b0;
      end else if (!en) begin
         meas = 0;
      end else if (!meas) begin
         meas  = 1;
         start = k;
      end else if ((k - start) >= (GATE + SYNC + 1) &&
                   ((k - start - (GATE + SYNC + 1)) % GATE) == 0) begin
         n = 0;
         for (int i = k - GATE + 1 - SYNC; i <= k - SYNC; i++) begin
            if (samp[i] && !samp[i-1]) n++;
         end
         exp_valid = 1'b1;
         exp_fa    = (n > 65535) ? 16'hFFFF : 16'(n);
         exp_oa    = (n > 65535);
         exp_fb    = (n > 15) ? 4'hF : 4'(n);
         exp_ob    = (n > 15);
      end
      exp_busy = meas;
   end

   // Cycle-by-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      check("valid_a", valid_a, exp_valid);
      check("busy_a",  busy_a,  exp_busy);
      check("freq_a",  freq_a,  exp_fa);
      check("ovf_a",   ovf_a,   exp_oa);
      check("valid_b", valid_b, exp_valid);
      check("busy_b",  busy_b,  exp_busy);
      check("freq_b",  freq_b,  exp_fb);
      check("ovf_b",   ovf_b,   exp_ob);
   end

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!valid_a && n < 300);
      check("valid_seen", valid_a, 1'b1);
   endtask

   typedef struct {
      int          period;
      logic [15:0] fa;
      logic        oa;
      logic [3:0]  fb;
      logic        ob;
   } vec_t;

   initial begin
      vec_t tbl [5];
      int   n;
      bit   saw_valid;

      tbl[0] = '{period: 10, fa: 16'd10, oa: 1'b0, fb: 4'd10, ob: 1'b0};
      tbl[1] = '{period: 4,  fa: 16'd25, oa: 1'b0, fb: 4'd15, ob: 1'b1};
      tbl[2] = '{period: 20, fa: 16'd5,  oa: 1'b0, fb: 4'd5,  ob: 1'b0};
      tbl[3] = '{period: 25, fa: 16'd4,  oa: 1'b0, fb: 4'd4,  ob: 1'b0};
      tbl[4] = '{period: 5,  fa: 16'd20, oa: 1'b0, fb: 4'd15, ob: 1'b1};

      // Reset held with enable high and a toggling input
      rst_n = 1'b0;
      en    = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("rst_freq",  freq_a,  16'h0);
         check("rst_valid", valid_a, 1'b0);
         check("rst_ovf",   ovf_a,   1'b0);
         check("rst_busy",  busy_a,  1'b0);
      end

      // First-result latency, then steady window period
      rst_n = 1'b1;
      wait_valid(n);
      check("first_latency", n, 104);
      check("first_freq", freq_a, 16'd10);
      wait_valid(n);
      check("window_period", n, 100);

      // Periodic inputs, including saturation of the narrow counter
      for (int t = 0; t < 5; t++) begin
         sig_period = tbl[t].period;
         wait_valid(n);
         wait_valid(n);
         check("tbl_freq_a", freq_a, tbl[t].fa);
         check("tbl_ovf_a",  ovf_a,  tbl[t].oa);
         check("tbl_freq_b", freq_b, tbl[t].fb);
         check("tbl_ovf_b",  ovf_b,  tbl[t].ob);
      end

      // Abort mid-window: no result, last value held, then clean restart
      sig_period = 10;
      wait_valid(n);
      wait_valid(n);
      repeat (50) @(negedge clk);
      en = 1'b0;
      saw_valid = 0;
      repeat (150) begin
         @(negedge clk);
         if (valid_a) saw_valid = 1;
      end
      check("abort_no_valid", saw_valid, 1'b0);
      check("abort_busy", busy_a, 1'b0);
      check("abort_hold", freq_a, 16'd10);
      en = 1'b1;
      wait_valid(n);
      check("restart_latency", n, 104);
      check("restart_freq", freq_a, 16'd10);

      // Single-cycle reset in the middle of a window
      repeat (40) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_freq",  freq_a,  16'h0);
      check("midrst_valid", valid_a, 1'b0);
      check("midrst_busy",  busy_a,  1'b0);
      check("midrst_ovf",   ovf_a,   1'b0);
      rst_n = 1'b1;

      // Input held high across reset release and enable rise
      sig_mode = 2;
      rst_n    = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_valid(n);
      check("hold_freq0", freq_a, 16'd0);
      wait_valid(n);
      check("hold_freq1", freq_a, 16'd0);
      en = 1'b0;
      repeat (5) @(negedge clk);
      en = 1'b1;
      wait_valid(n);
      check("hold_freq2", freq_a, 16'd0);

      // Random input with random aborts and resets, checked by the model
      sig_mode = 1;
      for (int r = 0; r < 30; r++) begin
         repeat ($urandom_range(20, 400)) @(negedge clk);
         case ($urandom_range(0, 5))
            0: begin
               en = 1'b0;
               repeat ($urandom_range(1, 6)) @(negedge clk);
               en = 1'b1;
            end
            1: begin
               rst_n = 1'b0;
               repeat ($urandom_range(1, 3)) @(negedge clk);
               rst_n = 1'b1;
            end
            default: ;
         endcase
      end
      repeat (250) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
